// File: rtl/mult_share_sched_if.sv
// Requester and response handshake bundle for mult_share_sched.
// master: requesters/consumer side, slave: scheduler side.
interface mult_share_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*128-1:0] req_x;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [383:0]           rsp_p;

  modport master (
    output req_valid,
    output req_x,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_p
  );

  modport slave (
    input  req_valid,
    input  req_x,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_p
  );
endinterface

// File: rtl/mult_share_sched.sv
// Round-robin sharing of one fixed-latency multiplier, credit-gated response FIFO.
// Optional latency checker: define MULT_SHARE_SCHED_LAT_CHECK_EN to add lat_err.
module mult_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int MUL_LAT    = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  mult_share_sched_if.slave   bus,
  output logic                mul_in_valid,
  output logic [127:0]        mul_X,
  output logic [64:0]         mul_X1X0,
  input  logic [383:0]        mul_P,
  input  logic                mul_out_valid,
`ifdef MULT_SHARE_SCHED_LAT_CHECK_EN
  output logic                lat_err,
`endif
  output logic                busy
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + MUL_LAT + 2) + 1;

  localparam logic [ID_W:0] NREQ    = (ID_W+1)'(NUM_REQ);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [ID_W-1:0] r_rr;
  logic [MUL_LAT:0] r_vld;
  logic [ID_W-1:0] r_id [MUL_LAT+1];
  logic [127:0]    r_x;
  logic [64:0]     r_x1x0;

  logic [PW-1:0]   r_wp;
  logic [PW-1:0]   r_rp;
  logic [PW:0]     r_cnt;
  logic [383:0]    r_mem_p  [FIFO_DEPTH];
  logic [ID_W-1:0] r_mem_id [FIFO_DEPTH];

  logic [CW-1:0]      w_infl;
  logic [CW-1:0]      w_used;
  logic               w_credit;
  logic [ID_W:0]      w_idx;
  logic [ID_W-1:0]    w_g;
  logic               w_found;
  logic               w_xfer;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_nxt_rr;
  logic [127:0]       w_op;
  logic [64:0]        w_fold;
  logic               w_push;
  logic               w_pop;
  logic               w_rsp_valid;

  // Stage 0 of the tag pipe is the issue register itself.
  always_comb begin
    w_infl = '0;
    for (int k = 0; k <= MUL_LAT; k++) begin
      w_infl = w_infl + CW'(r_vld[k]);
    end
  end

  assign w_used   = CW'(r_cnt) + w_infl;
  assign w_credit = w_used < DEPTH_C;

  always_comb begin
    w_found = 1'b0;
    w_g     = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr} + (ID_W+1)'(k);
      if (w_idx >= NREQ) begin
        w_idx = w_idx - NREQ;
      end
      if (!w_found && bus.req_valid[w_idx[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_g     = w_idx[ID_W-1:0];
      end
    end
  end

  assign w_xfer   = w_found & w_credit;
  assign w_gnt    = w_xfer ? (NUM_REQ'(1) << w_g) : '0;
  assign w_nxt_rr = ({1'b0, w_g} == NREQ - 1'b1) ? '0 : w_g + 1'b1;
  assign w_op     = bus.req_x[{w_g, 7'd0} +: 128];
  assign w_fold   = {1'b0, w_op[127:64]} + {1'b0, w_op[63:0]};

  assign bus.req_ready = w_gnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr   <= '0;
      r_vld  <= '0;
      r_x    <= '0;
      r_x1x0 <= '0;
      for (int k = 0; k <= MUL_LAT; k++) begin
        r_id[k] <= '0;
      end
    end else begin
      r_vld   <= {r_vld[MUL_LAT-1:0], w_xfer};
      r_id[0] <= w_g;
      for (int k = 1; k <= MUL_LAT; k++) begin
        r_id[k] <= r_id[k-1];
      end
      if (w_xfer) begin
        r_x    <= w_op;
        r_x1x0 <= w_fold;
        r_rr   <= w_nxt_rr;
      end
    end
  end

  // Credits guarantee a free slot for every returning product.
`ifdef MULT_SHARE_SCHED_LAT_CHECK_EN
  assign w_push = mul_out_valid & r_vld[MUL_LAT];
`else
  assign w_push = mul_out_valid;
`endif

  assign w_rsp_valid = r_cnt != '0;
  assign w_pop       = w_rsp_valid & bus.rsp_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        r_mem_p[k]  <= '0;
        r_mem_id[k] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem_p[r_wp]  <= mul_P;
        r_mem_id[r_wp] <= r_id[MUL_LAT];
        r_wp           <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef MULT_SHARE_SCHED_LAT_CHECK_EN
  logic r_lat_err;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lat_err <= 1'b0;
    end else if (mul_out_valid != r_vld[MUL_LAT]) begin
      r_lat_err <= 1'b1;
    end
  end

  assign lat_err = r_lat_err;
`endif

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_id    = r_mem_id[r_rp];
  assign bus.rsp_p     = r_mem_p[r_rp];
  assign mul_in_valid  = r_vld[0];
  assign mul_X         = r_x;
  assign mul_X1X0      = r_x1x0;
  assign busy          = (|r_vld) | w_rsp_valid;

endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench for mult_share_sched with a behavioural multiplier model.
// Define MULT_SHARE_SCHED_LAT_CHECK_EN to also exercise lat_err.
module tb_mult_share_sched;

  localparam int NUM_REQ    = 4;
  localparam int MUL_LAT    = 10;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W       = $clog2(NUM_REQ);

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mult_share_sched_if #(.NUM_REQ(NUM_REQ)) bus ();

  logic         mul_in_valid;
  logic [127:0] mul_X;
  logic [64:0]  mul_X1X0;
  logic [383:0] mul_P;
  logic         mul_out_valid;
  logic         busy;
  logic         inj = 1'b0;
`ifdef MULT_SHARE_SCHED_LAT_CHECK_EN
  logic         lat_err;
`endif

  mult_share_sched #(
    .NUM_REQ   (NUM_REQ),
    .MUL_LAT   (MUL_LAT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .mul_in_valid (mul_in_valid),
    .mul_X        (mul_X),
    .mul_X1X0     (mul_X1X0),
    .mul_P        (mul_P),
    .mul_out_valid(mul_out_valid),
`ifdef MULT_SHARE_SCHED_LAT_CHECK_EN
    .lat_err      (lat_err),
`endif
    .busy         (busy)
  );

  // Multiplier model: P = {zero pad, fold sum, X*X}, fixed latency, shares reset.
  logic [MUL_LAT-1:0] m_v;
  logic [383:0]       m_p [MUL_LAT];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_v <= '0;
    end else begin
      m_v     <= {m_v[MUL_LAT-2:0], mul_in_valid};
      m_p[0]  <= {63'd0, mul_X1X0, 256'(mul_X) * 256'(mul_X)};
      for (int k = 1; k < MUL_LAT; k++) m_p[k] <= m_p[k-1];
    end
  end

  assign mul_out_valid = m_v[MUL_LAT-1] | inj;
  assign mul_P         = m_p[MUL_LAT-1];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [383:0] act,
                     input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [64:0] fold(input logic [127:0] x);
    return 65'(x[127:64]) + 65'(x[63:0]);
  endfunction

  function automatic logic [383:0] prod(input logic [127:0] x);
    logic [255:0] sq;
    sq = 256'(x) * 256'(x);
    return {63'd0, fold(x), sq};
  endfunction

  function automatic logic [127:0] rnd128();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return '0;
      2:       return {64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
      default: return {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  typedef struct {
    logic [ID_W-1:0] id;
    logic [383:0]    p;
    int              cyc;
  } exp_t;

  exp_t sb [$];
  int   gq [$];
  int   cyc    = 0;
  int   n_xfer = 0;
  int   rr_m   = 0;
  int   outst  = 0;
  int   rsp_seen = 0;
  logic         prev_xfer = 1'b0;
  logic [127:0] prev_x    = '0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: spec-level grant model plus in-order response scoreboard.
  always @(negedge clock) begin
    int g;
    logic [NUM_REQ-1:0] eg;
    logic [127:0] x;
    exp_t e;
    if (!reset) begin
      sb.delete();
      rr_m      = 0;
      outst     = 0;
      prev_xfer = 1'b0;
    end else begin
      g  = -1;
      eg = '0;
      if (outst < FIFO_DEPTH) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (g < 0 && bus.req_valid[(rr_m + k) % NUM_REQ]) g = (rr_m + k) % NUM_REQ;
        end
      end
      if (g >= 0) eg[g] = 1'b1;
      chk("req_ready", 384'(bus.req_ready), 384'(eg));
      chk("mul_in_valid", 384'(mul_in_valid), 384'(prev_xfer));
      if (prev_xfer) begin
        chk("mul_X", 384'(mul_X), 384'(prev_x));
        chk("mul_X1X0", 384'(mul_X1X0), 384'(fold(prev_x)));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          gq.push_back(i);
          n_xfer++;
        end
      end
      if (bus.rsp_valid) rsp_seen++;
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual id=%0d required=none", bus.rsp_id);
        end else begin
          e = sb.pop_front();
          chk("rsp_id", 384'(bus.rsp_id), 384'(e.id));
          chk("rsp_p", bus.rsp_p, e.p);
          chk("rsp_latency_min", 384'(cyc - e.cyc >= MUL_LAT + 2), 384'(1));
        end
        if (outst > 0) outst--;
      end
      prev_xfer = (g >= 0);
      if (g >= 0) begin
        x      = bus.req_x[g*128 +: 128];
        prev_x = x;
        sb.push_back('{id: ID_W'(g), p: prod(x), cyc: cyc});
        outst++;
        rr_m = (g + 1) % NUM_REQ;
      end
    end
  end

  // Requester driver: 0 idle, 1 random, 2 always valid, 3 manual.
  int                     mode      = 0;
  logic [NUM_REQ-1:0]     man_valid = '0;
  logic [NUM_REQ*128-1:0] man_x     = '0;

  initial begin
    logic [NUM_REQ-1:0] xf;
    bus.req_valid = '0;
    bus.req_x     = '0;
    forever begin
      @(negedge clock);
      xf = bus.req_valid & bus.req_ready;
      @(posedge clock);
      #2;
      case (mode)
        1, 2: begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (xf[i] || !bus.req_valid[i]) begin
              bus.req_valid[i]         = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
              bus.req_x[i*128 +: 128]  = rnd128();
            end
          end
        end
        3: begin
          bus.req_valid = man_valid;
          bus.req_x     = man_x;
        end
        default: bus.req_valid = '0;
      endcase
    end
  end

  task automatic issue_one(input int id, input logic [127:0] x, output int gc);
    bit got = 0;
    gc = -1;
    man_x[id*128 +: 128] = x;
    man_valid[id]        = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clock);
      if (bus.req_valid[id] && bus.req_ready[id]) begin
        got = 1;
        gc  = cyc;
        man_valid[id] = 1'b0;
      end
    end
    if (!got) begin
      man_valid[id] = 1'b0;
      chk("issue_grant_timeout", 384'(0), 384'(1));
    end
  endtask

  task automatic drain();
    bit idle = 0;
    mode          = 0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clock);
    for (int n = 0; n < 300 && !idle; n++) begin
      @(negedge clock);
      if (!busy) idle = 1;
    end
    chk("drain_busy", 384'(busy), 384'(0));
    chk("drain_scoreboard", 384'(sb.size()), 384'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc;
    int n0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", 384'(bus.req_ready), 384'(0));
    chk("rst_mul_in_valid", 384'(mul_in_valid), 384'(0));
    chk("rst_mul_X", 384'(mul_X), 384'(0));
    chk("rst_mul_X1X0", 384'(mul_X1X0), 384'(0));
    chk("rst_rsp_valid", 384'(bus.rsp_valid), 384'(0));
    chk("rst_rsp_id", 384'(bus.rsp_id), 384'(0));
    chk("rst_rsp_p", bus.rsp_p, 384'(0));
    chk("rst_busy", 384'(busy), 384'(0));
    @(negedge clock);
    #2 reset = 1'b1;

    // Single request X=1 from requester 2.
    bus.rsp_ready = 1'b1;
    mode = 3;
    issue_one(2, 128'h1, gc);
    @(negedge clock);
    chk("t1_mul_X1X0", 384'(mul_X1X0), 384'(65'h1));
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      if (bus.rsp_valid) break;
    end
    chk("t1_latency", 384'(cyc - gc), 384'(MUL_LAT + 2));
    chk("t1_rsp_id", 384'(bus.rsp_id), 384'(2));
    chk("t1_rsp_p", bus.rsp_p, {63'd0, 65'd1, 256'd1});

    // All-ones operand: carry into bit 64 of the fold sum.
    issue_one(0, '1, gc);
    @(negedge clock);
    chk("t3_mul_X1X0", 384'(mul_X1X0), 384'(65'h1_FFFF_FFFF_FFFF_FFFE));
    drain();

    // Round-robin with every requester always valid.
    gq.delete();
    mode = 2;
    repeat (80) @(posedge clock);
    drain();
    chk("rr_grant_count", 384'(gq.size() >= 8), 384'(1));
    for (int i = 1; i < gq.size(); i++) begin
      chk("rr_order", 384'(gq[i]), 384'((gq[i-1] + 1) % NUM_REQ));
    end

    // Backpressure: credits cap grants at FIFO_DEPTH.
    bus.rsp_ready = 1'b0;
    n0   = n_xfer;
    mode = 2;
    repeat (40) @(posedge clock);
    @(negedge clock);
    chk("bp_grants", 384'(n_xfer - n0), 384'(FIFO_DEPTH));
    chk("bp_ready_zero", 384'(bus.req_ready), 384'(0));
    chk("bp_rsp_valid", 384'(bus.rsp_valid), 384'(1));
    @(posedge clock);
    #1 bus.rsp_ready = 1'b1;
    @(posedge clock);
    #1 bus.rsp_ready = 1'b0;
    n0 = n_xfer;
    repeat (30) @(posedge clock);
    @(negedge clock);
    chk("bp_one_more_grant", 384'(n_xfer - n0), 384'(1));
    drain();

    // Reset with 1 response queued and 3 issues in flight.
    bus.rsp_ready = 1'b0;
    mode = 3;
    issue_one(1, rnd128(), gc);
    repeat (MUL_LAT + 4) @(posedge clock);
    n0   = n_xfer;
    mode = 2;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (n_xfer - n0 >= 3) break;
    end
    mode = 0;
    chk("mid_grants", 384'(n_xfer - n0), 384'(3));
    @(posedge clock);
    @(posedge clock);
    #3 reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", 384'(bus.req_ready), 384'(0));
    chk("mid_rst_mul_in_valid", 384'(mul_in_valid), 384'(0));
    chk("mid_rst_mul_X", 384'(mul_X), 384'(0));
    chk("mid_rst_mul_X1X0", 384'(mul_X1X0), 384'(0));
    chk("mid_rst_rsp_valid", 384'(bus.rsp_valid), 384'(0));
    chk("mid_rst_rsp_id", 384'(bus.rsp_id), 384'(0));
    chk("mid_rst_rsp_p", bus.rsp_p, 384'(0));
    chk("mid_rst_busy", 384'(busy), 384'(0));
    repeat (3) @(posedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    chk("post_rst_busy", 384'(busy), 384'(0));
    rsp_seen = 0;
    repeat (30) @(posedge clock);
    chk("post_rst_no_stale", 384'(rsp_seen), 384'(0));
    gq.delete();
    mode = 2;
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("post_rst_rr_first", 384'((gq.size() > 0) ? gq[0] : 99), 384'(0));
    drain();

    // Random traffic with random consumer backpressure.
    mode = 1;
    for (int n = 0; n < 800; n++) begin
      @(posedge clock);
      #1 bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();

`ifdef MULT_SHARE_SCHED_LAT_CHECK_EN
    chk("lat_err_idle", 384'(lat_err), 384'(0));
    @(posedge clock);
    #1 inj = 1'b1;
    @(posedge clock);
    #1 inj = 1'b0;
    @(negedge clock);
    chk("lat_err_set", 384'(lat_err), 384'(1));
    chk("lat_err_no_push", 384'(bus.rsp_valid), 384'(0));
    repeat (5) @(posedge clock);
    @(negedge clock);
    chk("lat_err_sticky", 384'(lat_err), 384'(1));
    chk("lat_err_busy", 384'(busy), 384'(0));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_share_sched.md
Name: mult_share_sched

Overview:
- Round-robin scheduler that shares one fixed-latency, non-stallable 128x128 fold-Karatsuba multiplier pipeline between NUM_REQ requesters.
- Computes the 65-bit fold operand X1X0 for each issued operand.
- Tags every issue with its requester ID and routes each 384-bit product back through a response FIFO with valid/ready backpressure.
- Sits between the requester agents and the multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8); ID_W = clog2(NUM_REQ) is a derived localparam
- MUL_LAT, 10, cycles from mul_in_valid to mul_out_valid of the attached multiplier
- FIFO_DEPTH, 4, response FIFO entries (power of two, >=2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
- req_x  in  NUM_REQ*128  operands; requester i uses bits [128*i+127:128*i]
- mul_in_valid  out  1  issue strobe to multiplier
- mul_X  out  128  issued operand
- mul_X1X0  out  65  X[127:64]+X[63:0], zero-extended sum
- mul_P  in  384  multiplier product
- mul_out_valid  in  1  product valid
- rsp_valid  out  1  response FIFO head valid
- rsp_ready  in  1  consumer accepts head
- rsp_id  out  ID_W  requester ID of head
- rsp_p  out  384  product of head
- busy  out  1  any issue in flight or FIFO non-empty

Behaviour:
- Reset (reset=0, async) values: req_ready=0, mul_in_valid=0, mul_X=0, mul_X1X0=0, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0. Reset also clears the tag pipeline, the credit counter, and the FIFO pointers. The round-robin pointer resets to 0. Deassertion is sampled synchronously to clock.
- Credits: credits = FIFO_DEPTH - fifo_count - inflight, where inflight is the number of valid tag-pipe stages. Issuing is allowed only when credits>0. This guarantees every returning product has a FIFO slot, so the multiplier never stalls and no product is lost.
- Arbitration:
  - req_ready is combinational.
  - The grant goes to the first requester with req_valid=1, searching from rr_ptr upward with wrap.
  - A transfer occurs when req_valid & req_ready on requester g.
  - After a transfer, rr_ptr <= (g+1) mod NUM_REQ.
  - req_ready is all-zero when credits==0.
- Issue (registered): the cycle after a transfer, mul_in_valid=1, mul_X=operand, mul_X1X0={1'b0,X[127:64]}+{1'b0,X[63:0]}. At most one issue per cycle; full throughput is 1 per cycle.
- Tag pipe:
  - MUL_LAT-stage shift register of {valid, ID_W id}, loaded alongside mul_in_valid.
  - Tail valid coincides with mul_out_valid.
  - On mul_out_valid, push {tail id, mul_P} into the FIFO.
- FIFO:
  - Registered head outputs rsp_valid/rsp_id/rsp_p.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle is legal: count unchanged.
  - Push into a full FIFO cannot occur by construction.
  - Pop on empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Ordering: responses leave in issue order, regardless of requester.
- Simultaneous events: a pop in cycle t frees a credit that is usable for a grant in cycle t+1 (credits are computed from registered state).
- Reset mid-operation: all in-flight tags are dropped. The attached multiplier must also be reset on the same reset; the scheduler ignores any mul_out_valid while its tag tail is invalid.

Optional Feature:
- Macro: MULT_SHARE_SCHED_LAT_CHECK_EN.
- When defined:
  - Adds output port lat_err (1 bit, reset 0, sticky until reset).
  - lat_err sets when mul_out_valid differs from tag-pipe tail valid in any cycle.
  - A mismatched mul_out_valid with tail invalid is not pushed.
- When undefined:
  - No lat_err port.
  - mul_out_valid alone drives the push, using tail id.

Test Plan:
- Single request, X=128'h1 from req 2, rsp_ready=1: mul_X1X0=65'h1 one cycle after the grant. The response appears MUL_LAT+2 cycles after the grant with rsp_id=2 and rsp_p=the multiplier model output for X=1.
- All 4 requesters hold valid continuously, rsp_ready=1: grants follow 0,1,2,3,0,… in back-to-back cycles, bounded by FIFO_DEPTH credits. The product sequence matches the grant order.
- X=128'hFFFF…FFFF (all ones): mul_X1X0=65'h1_FFFF_FFFF_FFFF_FFFE (carry into bit 64).
- rsp_ready=0 with continuous requests: exactly FIFO_DEPTH=4 grants, then req_ready=0. Raising rsp_ready for one cycle pops one response, and exactly one new grant follows.
- reset asserted while 3 issues are in flight and the FIFO is partly full: all outputs are 0 immediately. After release, with the multiplier also reset, no stale responses appear, busy=0, and rr_ptr=0.
- With MULT_SHARE_SCHED_LAT_CHECK_EN defined, inject a spurious mul_out_valid with no issue: lat_err=1 next cycle and stays 1, and the FIFO count is unchanged.
